// File: rtl/morse_key_sequencer.sv
// morse_key_sequencer: turns a Morse key into letter symbol patterns and word spaces
// Ports: clk, rst (sync, active-low), tick (timebase enable), key_in (async key),
//        count_reset_sig (decoder ack) -> count (symbols), data_out (dot=0/dash=1),
//        send_data (letter/space valid until ack), busy (not IDLE).
// Optional: define MORSE_DEBOUNCE_EN to require 2 stable ticks before key_s changes.
module morse_key_sequencer #(
   parameter int DOT_MAX    = 3,
   parameter int LETTER_GAP = 3,
   parameter int WORD_GAP   = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       key_in,
   input  logic       count_reset_sig,
   output logic [3:0] count,
   output logic [3:0] data_out,
   output logic       send_data,
   output logic       busy
);
   typedef enum logic [2:0] {IDLE, MARK, GAP, SEND, WORD_WAIT, SEND_WORD} state_t;
   localparam logic [7:0] DOT_T = 8'(DOT_MAX);
   localparam logic [7:0] LG_T  = 8'(LETTER_GAP);
   localparam logic [7:0] WG_T  = 8'(WORD_GAP - LETTER_GAP);
   state_t     state_q, state_d;
   logic [7:0] tcnt_q, tcnt_d, tcnt_inc;
   logic [3:0] count_q, count_d, data_q, data_d;
   logic       send_q, send_d, busy_q, busy_d;
   logic       sync1_q, sync2_q, key_s;
`ifdef MORSE_DEBOUNCE_EN
   logic key_db_q, key_db_d, db_cnt_q, db_cnt_d;
   // a differing level must be seen on two consecutive ticks before it is accepted
   always_comb begin
      key_db_d = key_db_q;
      db_cnt_d = db_cnt_q;
      if (sync2_q == key_db_q) db_cnt_d = 1'b0;
      else if (tick) begin
         key_db_d = db_cnt_q ? sync2_q : key_db_q;
         db_cnt_d = ~db_cnt_q;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         key_db_q <= 1'b0;
         db_cnt_q <= 1'b0;
      end else begin
         key_db_q <= key_db_d;
         db_cnt_q <= db_cnt_d;
      end
   end
   assign key_s = key_db_q;
`else
   assign key_s = sync2_q;
`endif
   assign tcnt_inc = (tcnt_q == 8'hff) ? tcnt_q : tcnt_q + 8'd1;
   // key edges are checked before tick so an edge always clears tcnt
   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      count_d = count_q;
      data_d  = data_q;
      send_d  = send_q;
      case (state_q)
         IDLE: if (key_s) begin
            state_d = MARK;
            tcnt_d  = 8'd0;
         end
         MARK: if (!key_s) begin
            tcnt_d = 8'd0;
            if (tcnt_q == 8'd0) state_d = (count_q == 4'd0) ? IDLE : GAP;
            else begin
               state_d = GAP;
               // past four symbols the pattern freezes and count parks at 5
               if (count_q < 4'd4) begin
                  data_d  = {data_q[2:0], tcnt_q > DOT_T};
                  count_d = count_q + 4'd1;
               end else count_d = 4'd5;
            end
         end else if (tick) tcnt_d = tcnt_inc;
         GAP: if (key_s) begin
            state_d = MARK;
            tcnt_d  = 8'd0;
         end else if (tick) begin
            tcnt_d = tcnt_inc;
            if (tcnt_inc >= LG_T) begin
               state_d = SEND;
               send_d  = 1'b1;
               tcnt_d  = 8'd0;
            end
         end
         SEND: if (count_reset_sig) begin
            state_d = WORD_WAIT;
            tcnt_d  = 8'd0;
            send_d  = 1'b0;
            count_d = 4'd0;
            data_d  = 4'd0;
         end
         WORD_WAIT: if (key_s) begin
            state_d = MARK;
            tcnt_d  = 8'd0;
         end else if (tick) begin
            tcnt_d = tcnt_inc;
            if (tcnt_inc >= WG_T) begin
               state_d = SEND_WORD;
               tcnt_d  = 8'd0;
               send_d  = 1'b1;
               count_d = 4'd4;
               data_d  = 4'b1111;
            end
         end
         SEND_WORD: if (count_reset_sig) begin
            state_d = IDLE;
            send_d  = 1'b0;
            count_d = 4'd0;
            data_d  = 4'd0;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= IDLE;
         tcnt_q  <= 8'd0;
         count_q <= 4'd0;
         data_q  <= 4'd0;
         send_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync1_q <= key_in;
         sync2_q <= sync1_q;
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         count_q <= count_d;
         data_q  <= data_d;
         send_q  <= send_d;
         busy_q  <= busy_d;
      end
   end
   assign count     = count_q;
   assign data_out  = data_q;
   assign send_data = send_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_morse_key_sequencer.sv
// tb_morse_key_sequencer: directed checks of letters, word space, glitch and reset
module tb_morse_key_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       key_in = 1'b0;
   logic       count_reset_sig = 1'b0;
   logic [3:0] count, data_out;
   logic       send_data, busy;
   int         errors = 0;
   int         checks = 0;
   morse_key_sequencer dut (
      .clk(clk), .rst(rst), .tick(tick), .key_in(key_in),
      .count_reset_sig(count_reset_sig), .count(count), .data_out(data_out),
      .send_data(send_data), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic cyc(input logic t);
      tick = t;
      @(posedge clk);
      #1;
      tick = 1'b0;
   endtask
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         repeat (3) cyc(1'b0);
         cyc(1'b1);
      end
   endtask
   task automatic press(input int n);
      key_in = 1'b1;
      ticks(n);
   endtask
   task automatic release_key(input int n);
      key_in = 1'b0;
      ticks(n);
   endtask
   task automatic ack();
      count_reset_sig = 1'b1;
      cyc(1'b0);
      count_reset_sig = 1'b0;
   endtask
   task automatic outs(input string tag, input int c, input int d, input bit s, input bit b);
      chk({tag, ".count"}, {4'd0, count}, 8'(c));
      chk({tag, ".data"}, {4'd0, data_out}, 8'(d));
      chk({tag, ".send"}, {7'd0, send_data}, {7'd0, s});
      chk({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
   endtask
   task automatic word_space(input string tag);
      ack();
      outs({tag, "_ack"}, 0, 0, 1'b0, 1'b1);
      ticks(3);
      chk({tag, "_no_space_yet"}, {7'd0, send_data}, 8'd0);
      ticks(1);
      outs({tag, "_space"}, 4, 15, 1'b1, 1'b1);
      ack();
      outs({tag, "_idle"}, 0, 0, 1'b0, 1'b0);
   endtask
   initial begin
      repeat (3) cyc(1'b0);
      outs("reset", 0, 0, 1'b0, 1'b0);
      rst = 1'b1;
      cyc(1'b0);
      // E: one dot then a letter gap
      press(2);
      release_key(3);
      outs("E", 1, 0, 1'b1, 1'b1);
      repeat (5) cyc(1'b0);
      outs("E_hold", 1, 0, 1'b1, 1'b1);
      word_space("E");
      // N: dash then dot -> 2'b10
      press(5);
      release_key(1);
      press(2);
      release_key(3);
      outs("N", 2, 2, 1'b1, 1'b1);
      word_space("N");
      // five dots -> error letter, pattern frozen at four dots
      for (int i = 0; i < 4; i++) begin
         press(2);
         release_key(1);
      end
      press(2);
      release_key(3);
      outs("five", 5, 0, 1'b1, 1'b1);
      word_space("five");
      // single-cycle key pulse without a tick is discarded
      key_in = 1'b1;
      cyc(1'b0);
      key_in = 1'b0;
      repeat (6) cyc(1'b0);
      outs("glitch", 0, 0, 1'b0, 1'b0);
      ticks(4);
      outs("glitch_later", 0, 0, 1'b0, 1'b0);
      // ack outside SEND is ignored
      ack();
      outs("stray_ack", 0, 0, 1'b0, 1'b0);
      // reset during SEND of a 3-symbol letter (dash dot dash = 3'b101)
      press(5);
      release_key(1);
      press(2);
      release_key(1);
      press(5);
      release_key(3);
      outs("K", 3, 5, 1'b1, 1'b1);
      rst = 1'b0;
      cyc(1'b0);
      outs("rst_send", 0, 0, 1'b0, 1'b0);
      rst = 1'b1;
      ticks(10);
      outs("rst_after", 0, 0, 1'b0, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
